// File: rtl/modinv_if.sv
// rtl/modinv_if.sv - request/result stream bundle for the modular inverter
interface modinv_if #(
    parameter int LOGQ = 28
);
    logic            in_valid;
    logic            in_ready;
    logic [LOGQ-1:0] in_a;
    logic [LOGQ-1:0] q;
    logic            out_valid;
    logic            out_ready;
    logic [LOGQ-1:0] out_c;
    logic            out_err;

    modport master (
        output in_valid, in_a, q, out_ready,
        input  in_ready, out_valid, out_c, out_err
    );

    modport slave (
        input  in_valid, in_a, q, out_ready,
        output in_ready, out_valid, out_c, out_err
    );
endinterface

// File: rtl/modinv.sv
// rtl/modinv.sv - binary extended-Euclid modular inverter, one reduction step per cycle
module modinv #(
    parameter int LOGQ = 28
) (
    input  logic     clk,
    input  logic     rst,
    modinv_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state;
    logic [LOGQ-1:0] qr;
    logic [LOGQ-1:0] u;
    logic [LOGQ-1:0] v;
    logic [LOGQ-1:0] x1;
    logic [LOGQ-1:0] x2;
    logic [LOGQ-1:0] c;
    logic            err;
    logic            illegal;

    localparam logic [LOGQ-1:0] ONE   = LOGQ'(1);
    localparam logic [LOGQ-1:0] THREE = LOGQ'(3);

    // Halving mod an odd modulus: add qr to odd x first, keeping the carry bit.
    function automatic logic [LOGQ-1:0] halve(input logic [LOGQ-1:0] x,
                                               input logic [LOGQ-1:0] m);
        logic [LOGQ:0] s;
        s = {1'b0, x} + (x[0] ? {1'b0, m} : {(LOGQ+1){1'b0}});
        return s[LOGQ:1];
    endfunction

    // Both operands lie in [0,m), so the wrapped difference plus m is exact.
    function automatic logic [LOGQ-1:0] sub_mod(input logic [LOGQ-1:0] a,
                                                 input logic [LOGQ-1:0] b,
                                                 input logic [LOGQ-1:0] m);
        return (a >= b) ? (a - b) : (a - b + m);
    endfunction

    always_comb begin
        illegal = 1'b0;
        if (!bus.q[0] || bus.q < THREE || bus.in_a == '0 || bus.in_a >= bus.q)
            illegal = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            qr    <= '0;
            u     <= '0;
            v     <= '0;
            x1    <= '0;
            x2    <= '0;
            c     <= '0;
            err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        qr <= bus.q;
                        u  <= bus.in_a;
                        v  <= bus.q;
                        x1 <= ONE;
                        x2 <= '0;
                        if (illegal) begin
                            c     <= '0;
                            err   <= 1'b1;
                            state <= DONE;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (u == ONE) begin
                        c     <= x1;
                        err   <= 1'b0;
                        state <= DONE;
                    end else if (v == ONE) begin
                        c     <= x2;
                        err   <= 1'b0;
                        state <= DONE;
                    end else if (u == '0 || v == '0) begin
                        c     <= '0;
                        err   <= 1'b1;
                        state <= DONE;
                    end else if (!u[0]) begin
                        u  <= u >> 1;
                        x1 <= halve(x1, qr);
                    end else if (!v[0]) begin
                        v  <= v >> 1;
                        x2 <= halve(x2, qr);
                    end else if (u >= v) begin
                        u  <= u - v;
                        x1 <= sub_mod(x1, x2, qr);
                    end else begin
                        v  <= v - u;
                        x2 <= sub_mod(x2, x1, qr);
                    end
                end
                DONE: begin
                    if (bus.out_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.out_c     = c;
    assign bus.out_err   = err;
endmodule

// File: tb/tb_modinv.sv
// tb/tb_modinv.sv - randomized self-checking bench for modinv against an extended-Euclid model
module tb_modinv;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    modinv_if #(.LOGQ(28)) bus28();
    modinv_if #(.LOGQ(64)) bus64();

    modinv #(.LOGQ(28)) dut28 (.clk(clk), .rst(rst), .bus(bus28));
    modinv #(.LOGQ(64)) dut64 (.clk(clk), .rst(rst), .bus(bus64));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Division-based extended Euclid: an independent route to the same inverse.
    function automatic void ref_inv(input longint a, input longint m,
                                    output longint c, output bit e);
        longint r0, r1, t0, t1, qt, tmp;
        c = 0;
        e = 1'b1;
        if (m % 2 == 0 || m < 3 || a == 0 || a >= m) return;
        r0 = m; r1 = a; t0 = 0; t1 = 1;
        while (r1 != 0) begin
            qt  = r0 / r1;
            tmp = r0 - qt * r1; r0 = r1; r1 = tmp;
            tmp = t0 - qt * t1; t0 = t1; t1 = tmp;
        end
        if (r0 != 1) return;
        c = ((t0 % m) + m) % m;
        e = 1'b0;
    endfunction

    task automatic req28(input logic [27:0] a, input logic [27:0] m,
                         output logic [27:0] c, output logic e, output int lat);
        int i;
        i = 0;
        while (!bus28.in_ready && i < 1000) begin
            @(posedge clk); #1; i++;
        end
        check("in_ready_before_req", {63'd0, bus28.in_ready}, 64'd1);
        bus28.in_a     = a;
        bus28.q        = m;
        bus28.in_valid = 1'b1;
        @(posedge clk); #1;
        bus28.in_valid = 1'b0;
        bus28.in_a     = 28'($urandom);
        bus28.q        = 28'($urandom);
        lat = 1;
        while (!bus28.out_valid && lat < 200) begin
            @(posedge clk); #1; lat++;
        end
        check("out_valid_timeout", {63'd0, bus28.out_valid}, 64'd1);
        c = bus28.out_c;
        e = bus28.out_err;
        bus28.out_ready = 1'b1;
        @(posedge clk); #1;
        bus28.out_ready = 1'b0;
    endtask

    task automatic run_ref(input string tag, input logic [27:0] a, input logic [27:0] m);
        logic [27:0] c;
        logic        e;
        int          lat;
        longint      ec;
        bit          ee;
        ref_inv(longint'(a), longint'(m), ec, ee);
        req28(a, m, c, e, lat);
        check({tag, "_c"}, 64'(c), 64'(ec));
        check({tag, "_err"}, 64'(e), 64'(ee));
        check({tag, "_lat_bound"}, 64'(lat <= 4 * 28 + 2), 64'd1);
    endtask

    initial begin
        logic [27:0] c, a, m;
        logic        e;
        int          lat, i;
        bit          seen;

        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus28.in_valid = 1'b0; bus28.in_a = '0; bus28.q = '0; bus28.out_ready = 1'b0;
        bus64.in_valid = 1'b0; bus64.in_a = '0; bus64.q = '0; bus64.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  64'(bus28.in_ready),  64'd1);
        check("rst_out_valid", 64'(bus28.out_valid), 64'd0);
        check("rst_out_c",     64'(bus28.out_c),     64'd0);
        check("rst_out_err",   64'(bus28.out_err),   64'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        req28(28'd3, 28'd17, c, e, lat);
        check("q17_a3_c", 64'(c), 64'd6);
        check("q17_a3_err", 64'(e), 64'd0);
        req28(28'd1, 28'd17, c, e, lat);
        check("q17_a1_c", 64'(c), 64'd1);
        check("q17_a1_lat", 64'(lat), 64'd2);
        req28(28'd16, 28'd17, c, e, lat);
        check("q17_a16_c", 64'(c), 64'd16);

        req28(28'd5, 28'd15, c, e, lat);
        check("gcd_err", 64'(e), 64'd1);
        check("gcd_c", 64'(c), 64'd0);
        req28(28'd0, 28'd17, c, e, lat);
        check("a0_err", 64'(e), 64'd1);
        check("a0_lat", 64'(lat), 64'd1);
        req28(28'd3, 28'd16, c, e, lat);
        check("q_even_err", 64'(e), 64'd1);
        req28(28'd17, 28'd17, c, e, lat);
        check("a_eq_q_err", 64'(e), 64'd1);
        check("a_eq_q_c", 64'(c), 64'd0);
        req28(28'd1, 28'd1, c, e, lat);
        check("q1_err", 64'(e), 64'd1);

        for (int k = 0; k < 150; k++) begin
            a = (k == 0) ? 28'd1 : (k == 1) ? 28'd7680 : 28'($urandom_range(1, 7680));
            req28(a, 28'd7681, c, e, lat);
            check("q7681_product", 64'((longint'(a) * longint'(c)) % 7681), 64'd1);
            check("q7681_err", 64'(e), 64'd0);
            check("q7681_lat_bound", 64'(lat <= 4 * 28 + 2), 64'd1);
        end

        for (int k = 0; k < 40; k++) begin
            m = 28'($urandom) | 28'd1;
            a = 28'($urandom % 32'(m));
            run_ref("rand28", a, m);
        end

        // Result held while the consumer stalls; a waiting request must not slip in.
        bus28.in_a = 28'd3; bus28.q = 28'd17; bus28.in_valid = 1'b1;
        @(posedge clk); #1;
        bus28.in_valid = 1'b0;
        i = 0;
        while (!bus28.out_valid && i < 200) begin
            @(posedge clk); #1; i++;
        end
        bus28.in_a = 28'd16; bus28.q = 28'd17; bus28.in_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            check("bp_out_valid", 64'(bus28.out_valid), 64'd1);
            check("bp_out_c", 64'(bus28.out_c), 64'd6);
            check("bp_in_ready", 64'(bus28.in_ready), 64'd0);
            @(posedge clk); #1;
        end
        bus28.out_ready = 1'b1;
        @(posedge clk); #1;
        bus28.out_ready = 1'b0;
        check("bp_after_consume_in_ready", 64'(bus28.in_ready), 64'd1);
        check("bp_after_consume_out_valid", 64'(bus28.out_valid), 64'd0);
        @(posedge clk); #1;
        bus28.in_valid = 1'b0;
        check("bp_accepted_next", 64'(bus28.in_ready), 64'd0);
        i = 0;
        while (!bus28.out_valid && i < 200) begin
            @(posedge clk); #1; i++;
        end
        check("bp_second_c", 64'(bus28.out_c), 64'd16);
        bus28.out_ready = 1'b1;
        @(posedge clk); #1;
        bus28.out_ready = 1'b0;

        // Reset in the middle of a long computation.
        bus28.in_a = 28'd123456789; bus28.q = 28'd268369921; bus28.in_valid = 1'b1;
        @(posedge clk); #1;
        bus28.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("midrun_busy", 64'(bus28.in_ready), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrun_rst_in_ready",  64'(bus28.in_ready),  64'd1);
        check("midrun_rst_out_valid", 64'(bus28.out_valid), 64'd0);
        check("midrun_rst_out_c",     64'(bus28.out_c),     64'd0);
        check("midrun_rst_out_err",   64'(bus28.out_err),   64'd0);
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 150; k++) begin
            @(posedge clk); #1;
            if (bus28.out_valid) seen = 1'b1;
        end
        check("midrun_no_result", 64'(seen), 64'd0);
        run_ref("midrun_fresh", 28'd123456789, 28'd268369921);

        bus64.in_a = 64'd2; bus64.q = 64'hFFFFFFFF00000001; bus64.in_valid = 1'b1;
        @(posedge clk); #1;
        bus64.in_valid = 1'b0;
        lat = 1;
        while (!bus64.out_valid && lat < 300) begin
            @(posedge clk); #1; lat++;
        end
        check("w64_out_valid", 64'(bus64.out_valid), 64'd1);
        check("w64_c", bus64.out_c, 64'h7FFFFFFF80000001);
        check("w64_err", 64'(bus64.out_err), 64'd0);
        check("w64_lat_bound", 64'(lat <= 4 * 64 + 2), 64'd1);
        bus64.out_ready = 1'b1;
        @(posedge clk); #1;
        bus64.out_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
